// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg: shared states, register map and bit positions for the frame sequencer
package frame_seq_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ADVANCE,
    ST_FRAME_END
  } state_t;
  localparam logic [1:0] ADDR_CTRL        = 2'd0;
  localparam logic [1:0] ADDR_STATUS      = 2'd1;
  localparam logic [1:0] ADDR_FRAME_COUNT = 2'd2;
  localparam logic [1:0] ADDR_BUF_SEL     = 2'd3;
  localparam int CTRL_START   = 0;
  localparam int CTRL_CONT    = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_ABORT   = 3;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVERRUN = 2;
  localparam int BLK_SIZE     = 8;
endpackage

// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: control bus, interrupt and DCT engine conduit of the frame sequencer
interface frame_sequencer_if;
  logic [1:0]  avs_s0_address;
  logic        avs_s0_write;
  logic [31:0] avs_s0_writedata;
  logic        avs_s0_read;
  logic [31:0] avs_s0_readdata;
  logic        ins_irq0_irq;
  logic        coe_dct_start;
  logic [7:0]  coe_dct_blk_x;
  logic [7:0]  coe_dct_blk_y;
  logic        coe_dct_done;
  logic        coe_src_sel;
  logic        coe_dst_sel;
  modport master (
    output avs_s0_address, avs_s0_write, avs_s0_writedata, avs_s0_read, coe_dct_done,
    input  avs_s0_readdata, ins_irq0_irq, coe_dct_start, coe_dct_blk_x, coe_dct_blk_y,
           coe_src_sel, coe_dst_sel
  );
  modport slave (
    input  avs_s0_address, avs_s0_write, avs_s0_writedata, avs_s0_read, coe_dct_done,
    output avs_s0_readdata, ins_irq0_irq, coe_dct_start, coe_dct_blk_x, coe_dct_blk_y,
           coe_src_sel, coe_dst_sel
  );
endinterface

// File: rtl/block_addr_counter.sv
// block_addr_counter: raster-order block coordinate counter with clear, advance and last-block flag
module block_addr_counter #(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input  logic       csi_clk,
  input  logic       rsi_reset,
  input  logic       clr,
  input  logic       adv,
  output logic [7:0] blk_x,
  output logic [7:0] blk_y,
  output logic       last
);
  localparam logic [7:0] X_MAX = 8'(COLS - 1);
  localparam logic [7:0] Y_MAX = 8'(ROWS - 1);
  logic x_wrap;
  assign x_wrap = blk_x == X_MAX;
  assign last = x_wrap && blk_y == Y_MAX;
  // walk columns first, stepping the row when the column wraps; clear wins over advance
  always_ff @(posedge csi_clk) begin
    if (rsi_reset || clr) begin
      blk_x <= '0;
      blk_y <= '0;
    end else if (adv) begin
      blk_x <= x_wrap ? '0 : blk_x + 8'd1;
      blk_y <= x_wrap ? blk_y + 8'd1 : blk_y;
    end
  end
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: walks the DCT engine over a frame in 8x8 blocks under Avalon-MM control
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int FRAME_W = 320,
  parameter int FRAME_H = 240
) (
  input logic               csi_clk,
  input logic               rsi_reset,
  frame_sequencer_if.slave  s0
);
  localparam int COLS = FRAME_W / BLK_SIZE;
  localparam int ROWS = FRAME_H / BLK_SIZE;
  state_t state, state_nx;
  logic        continuous, irq_en, done, overrun, src_sel, dst_sel;
  logic [15:0] frame_count;
  logic [1:0]  buf_prog;
  logic [31:0] wd;
  logic        wr_ctrl, wr_stat, wr_buf, abort_req, start_req;
  logic        last, cnt_clr, cnt_adv, load_sel, frame_fire, dct_start, busy;
  logic [7:0]  blk_x, blk_y;
  logic        unused_wd;
  assign wd        = s0.avs_s0_writedata;
  assign unused_wd = ^wd[31:4];
  assign wr_ctrl   = s0.avs_s0_write && s0.avs_s0_address == ADDR_CTRL;
  assign wr_stat   = s0.avs_s0_write && s0.avs_s0_address == ADDR_STATUS;
  assign wr_buf    = s0.avs_s0_write && s0.avs_s0_address == ADDR_BUF_SEL;
  assign abort_req = wr_ctrl && wd[CTRL_ABORT];
  assign start_req = wr_ctrl && wd[CTRL_START] && !wd[CTRL_ABORT];
  block_addr_counter #(.COLS(COLS), .ROWS(ROWS)) u_addr (
    .csi_clk   (csi_clk),
    .rsi_reset (rsi_reset),
    .clr       (cnt_clr),
    .adv       (cnt_adv),
    .blk_x     (blk_x),
    .blk_y     (blk_y),
    .last      (last)
  );
  // state register
  always_ff @(posedge csi_clk) begin
    state <= rsi_reset ? ST_IDLE : state_nx;
  end
  // next-state logic; abort preempts every state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      state_nx = start_req ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:     state_nx = ST_WAIT;
      ST_WAIT:      state_nx = s0.coe_dct_done ? ST_ADVANCE : ST_WAIT;
      ST_ADVANCE:   state_nx = last ? ST_FRAME_END : ST_ISSUE;
      ST_FRAME_END: state_nx = continuous ? ST_ISSUE : ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
    if (abort_req) state_nx = ST_IDLE;
  end
  // state-decoded outputs and datapath strobes; abort suppresses all frame side effects
  always_comb begin
    dct_start  = state == ST_ISSUE;
    busy       = state != ST_IDLE;
    load_sel   = state == ST_IDLE && start_req;
    frame_fire = state == ST_FRAME_END && !abort_req;
    cnt_adv    = state == ST_ADVANCE && !last && !abort_req;
    cnt_clr    = load_sel || (frame_fire && continuous);
  end
  // control, status, frame counter and active buffer selects
  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      continuous  <= 1'b0;
      irq_en      <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
      buf_prog    <= '0;
      src_sel     <= 1'b0;
      dst_sel     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        continuous <= wd[CTRL_CONT];
        irq_en     <= wd[CTRL_IRQ_EN];
      end
      if (wr_buf) buf_prog <= wd[1:0];
      done    <= frame_fire || (done && !(wr_stat && wd[STAT_DONE]));
      overrun <= (s0.coe_dct_done && state != ST_WAIT) || (overrun && !(wr_stat && wd[STAT_OVERRUN]));
      if (frame_fire) frame_count <= frame_count + 16'd1;
      if (load_sel) {dst_sel, src_sel} <= buf_prog;
      else if (frame_fire && continuous) {dst_sel, src_sel} <= ~{dst_sel, src_sel};
    end
  end
  // registered read mux, one cycle latency, returns pre-write values
  always_ff @(posedge csi_clk) begin
    if (rsi_reset || !s0.avs_s0_read) s0.avs_s0_readdata <= '0;
    else s0.avs_s0_readdata <=
      s0.avs_s0_address == ADDR_CTRL        ? {29'b0, irq_en, continuous, 1'b0} :
      s0.avs_s0_address == ADDR_STATUS      ? {29'b0, overrun, done, busy} :
      s0.avs_s0_address == ADDR_FRAME_COUNT ? {16'b0, frame_count} :
                                              {28'b0, dst_sel, src_sel, buf_prog};
  end
  assign s0.ins_irq0_irq  = done && irq_en;
  assign s0.coe_dct_start = dct_start;
  assign s0.coe_dct_blk_x = blk_x;
  assign s0.coe_dct_blk_y = blk_y;
  assign s0.coe_src_sel   = src_sel;
  assign s0.coe_dst_sel   = dst_sel;
endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Avalon-MM–configured sequencer that walks the DCT compression engine across one video frame in 8×8 blocks. It issues one block command at a time, waits for the engine's completion pulse, and advances the block coordinates in raster order. At each frame end it updates a frame counter and raises a done/interrupt flag. In continuous mode it ping-pongs the source and destination frame-buffer selects. It sits between the Nios-side control bus and the DCT datapath, and replaces software toggling of frame selects.

## Interface
- FRAME_W, 320: frame width in pixels; multiple of 8.
- FRAME_H, 240: frame height in pixels; multiple of 8.
- csi_clk  in  1  sole clock.
- rsi_reset  in  1  synchronous, active-high reset.
- avs_s0_address  in  2  register select: 0 CTRL, 1 STATUS, 2 FRAME_COUNT, 3 BUF_SEL.
- avs_s0_write  in  1  write strobe.
- avs_s0_writedata  in  32  write data.
- avs_s0_read  in  1  read strobe.
- avs_s0_readdata  out  32  read data, fixed read latency 1.
- ins_irq0_irq  out  1  level interrupt.
- coe_dct_start  out  1  one-cycle block command pulse.
- coe_dct_blk_x  out  8  block column, 0..FRAME_W/8-1.
- coe_dct_blk_y  out  8  block row, 0..FRAME_H/8-1.
- coe_dct_done  in  1  one-cycle block-complete pulse from the engine.
- coe_src_sel  out  1  active source frame buffer.
- coe_dst_sel  out  1  active destination frame buffer.

## Operation
- **CTRL write bits:**
  - [0] start: self-clearing.
  - [1] continuous.
  - [2] irq_en.
  - [3] abort: self-clearing.
- **CTRL read:** returns {irq_en, continuous} in bits [2:1]; all other bits read 0.
- **STATUS:**
  - [0] busy (read-only).
  - [1] done (sticky; write 1 to clear).
  - [2] overrun (sticky; write 1 to clear). Set when coe_dct_done arrives outside WAIT.
- **FRAME_COUNT:** 16-bit completed-frame count, zero-extended on read, wraps 0xFFFF→0. Writes are ignored.
- **BUF_SEL:**
  - Bits [1:0] hold the programmed {dst, src} and are writable at any time.
  - Read returns programmed bits in [1:0] and active {coe_dst_sel, coe_src_sel} in [3:2].
- **FSM states:** IDLE, ISSUE, WAIT, ADVANCE, FRAME_END.
  - **IDLE:**
    - A CTRL write with start=1 loads the active selects from BUF_SEL, clears x and y, and goes to ISSUE.
    - start=1 outside IDLE is ignored.
  - **ISSUE:** coe_dct_start=1; next state WAIT.
  - **WAIT:** coe_dct_done moves to ADVANCE; otherwise stay.
  - **ADVANCE:**
    - On the last block (x=W/8-1, y=H/8-1), go to FRAME_END.
    - Otherwise increment x. When x wraps to 0, increment y. Go to ISSUE.
  - **FRAME_END:**
    - Increment frame_count and set done.
    - If continuous=1: invert both active selects, clear x and y, go to ISSUE.
    - Otherwise go to IDLE.
- **continuous sampling:** continuous is read in FRAME_END. Clearing it mid-frame lets the current frame finish, then the block stops.
- **abort:**
  - Takes effect in any state: go to IDLE the next cycle.
  - Does not set done and does not change frame_count or the selects.
  - Overrides start in the same write.
- **busy:** 1 in every state except IDLE.
- **ins_irq0_irq:** = done & irq_en.
- **Reset values:**
  - All registers and outputs 0 and state IDLE.
  - Specifically: readdata, irq, dct_start, blk_x/blk_y, src_sel/dst_sel, frame_count, done, overrun, continuous, irq_en.
- **Reset mid-frame:** no completion side effects. A later coe_dct_done arriving in IDLE sets overrun.

## Timing
- CTRL start write in cycle N → ISSUE in N+1, with coe_dct_start high in N+1.
- All FSM outputs are Moore and registered. blk_x/blk_y are stable from ISSUE through WAIT.
- coe_dct_done in cycle M (WAIT) → ADVANCE in M+1 → ISSUE with new coordinates in M+2.
- Last-block done in M → FRAME_END in M+2. done and irq are visible in M+3.
  - Continuous mode: next ISSUE in M+3 with toggled selects.
- Readdata is valid the cycle after avs_s0_read.
- Same-cycle register write and read: the read returns the pre-write value.
- Done set (FRAME_END) and W1C clear in the same cycle: set wins.
- The engine must not pulse done in the same cycle as start; such a pulse is treated as outside WAIT (overrun).

## Structure
- Shared package frame_seq_pkg holds:
  - the state enum;
  - register address constants (CTRL, STATUS, FRAME_COUNT, BUF_SEL);
  - CTRL/STATUS bit-index constants;
  - the block-size constant 8.
- One natural sub-module: block_addr_counter (x/y raster counter with clear, advance and last-block flag). The register file and FSM stay in the top module.

## Test plan
Test plan scenarios use FRAME_W=16, FRAME_H=16 (4 blocks).
- **Single frame:** reset, write CTRL=0x5, answer each start with done 3 cycles later → starts at (0,0),(1,0),(0,1),(1,1); STATUS=0x2, FRAME_COUNT=1, irq=1, busy=0.
- **Continuous ping-pong:** BUF_SEL=0x2, CTRL=0x3 → frame 1 src=0/dst=1, frame 2 src=1/dst=0. Clear continuous mid-frame 2 → the block stops after frame 2 with FRAME_COUNT=2.
- **Abort:** CTRL=0x8 during WAIT of block 2 → IDLE next cycle, done=0, FRAME_COUNT unchanged. The following done pulse sets overrun (STATUS=0x4).
- **Restart-while-busy:** a start write in WAIT is ignored, with no extra dct_start pulse. W1C 0x2 clears done and drops irq the next cycle.
- **Reset mid-frame:** assert rsi_reset in WAIT → all outputs 0 the following cycle; readback of all registers returns 0.
- **Wrap:** force 0xFFFF completed frames (or use a fast frame count) → the next frame end reads FRAME_COUNT=0.
